// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Registered ALU execute stage (AND/OR/ADD/SUB) with
//                valid/ready handshakes on both sides and a 2-entry output
//                buffer (output register + skid register).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  localparam logic [3:0] C_OP_AND = 4'b0000;
  localparam logic [3:0] C_OP_OR  = 4'b0001;
  localparam logic [3:0] C_OP_ADD = 4'b0010;
  localparam logic [3:0] C_OP_SUB = 4'b0110;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_illegal;
  logic [WIDTH-1:0] r_skid_result;
  logic             r_skid_zero;
  logic             r_skid_illegal;

  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_illegal;
  logic             w_accept;
  logic             w_pop;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_move_skid;

  // Status flags come straight from the registered state, so in_ready has
  // no combinational dependence on out_ready.
  assign in_ready   = (r_state != TWO);
  assign out_valid  = (r_state != EMPTY);
  assign w_accept   = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;

  assign result     = r_out_result;
  assign zero       = r_out_zero;
  assign illegal_op = r_out_illegal;

  // ALU: unrecognised codes (X/Z included) fall to default and give 0/illegal.
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (operation)
      C_OP_AND: w_result = src_a & src_b;
      C_OP_OR:  w_result = src_a | src_b;
      C_OP_ADD: w_result = src_a + src_b;
      C_OP_SUB: w_result = src_a - src_b;
      default:  w_illegal = 1'b1;
    endcase
    w_zero = !w_illegal && (w_result == '0);
  end

  // Next-state and buffer load controls.
  always_comb begin
    w_state_next = r_state;
    w_load_out   = 1'b0;
    w_load_skid  = 1'b0;
    w_move_skid  = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_next = ONE;
          w_load_out   = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_pop) begin
          w_load_out = 1'b1;
        end else if (w_accept) begin
          w_state_next = TWO;
          w_load_skid  = 1'b1;
        end else if (w_pop) begin
          w_state_next = EMPTY;
        end
      end
      TWO: begin
        if (w_pop) begin
          w_state_next = ONE;
          w_move_skid  = 1'b1;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output register: loaded with a fresh entry or with the skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_result  <= '0;
      r_out_zero    <= 1'b0;
      r_out_illegal <= 1'b0;
    end else if (w_load_out) begin
      r_out_result  <= w_result;
      r_out_zero    <= w_zero;
      r_out_illegal <= w_illegal;
    end else if (w_move_skid) begin
      r_out_result  <= r_skid_result;
      r_out_zero    <= r_skid_zero;
      r_out_illegal <= r_skid_illegal;
    end
  end

  // Skid register: catches the entry accepted while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_result  <= '0;
      r_skid_zero    <= 1'b0;
      r_skid_illegal <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_result  <= w_result;
      r_skid_zero    <= w_zero;
      r_skid_illegal <= w_illegal;
    end
  end

endmodule
`default_nettype wire
